// File: rtl/comb_capture_if.sv
// Handshake bundle between the combinational result stage, the capture FIFO
// and its consumer. master drives the beat and out_ready; slave is the capture block.
interface comb_capture_if #(
  parameter int size = 1
);
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] in_out1;
  logic [size-1:0] in_out2;
  logic [size-1:0] in_out3;
  logic [size-1:0] in_out4;
  logic [size-1:0] in_out5;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] q_out1;
  logic [size-1:0] q_out2;
  logic [size-1:0] q_out3;
  logic [size-1:0] q_out4;
  logic [size-1:0] q_out5;
  logic            mismatch;
  logic [7:0]      err_count;

  modport master (
    output in_valid, in_out1, in_out2, in_out3, in_out4, in_out5, out_ready,
    input  in_ready, out_valid, q_out1, q_out2, q_out3, q_out4, q_out5,
           mismatch, err_count
  );

  modport slave (
    input  in_valid, in_out1, in_out2, in_out3, in_out4, in_out5, out_ready,
    output in_ready, out_valid, q_out1, q_out2, q_out3, q_out4, q_out5,
           mismatch, err_count
  );
endinterface

// File: rtl/comb_capture.sv
// Two-entry capture FIFO for five result fields, with a consistency check on
// every accepted beat (field 4 must equal field 1, field 5 must be fully known).
module comb_capture #(
  parameter int size = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  comb_capture_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  typedef logic [4:0][size-1:0] entry_t;

  state_e     state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       in_ready_q, in_ready_d;
  logic       mismatch_q, mismatch_d;
  logic [7:0] err_count_q, err_count_d;

  entry_t in_entry;
  entry_t head;
  logic   push;
  logic   pop;
  logic   check_fail;

  assign in_entry = {bus.in_out5, bus.in_out4, bus.in_out3, bus.in_out2, bus.in_out1};
  assign push     = bus.in_valid & in_ready_q;
  assign pop      = (state_q != EMPTY) & bus.out_ready;

  // Case-inequality so an X/Z bit on either side of the field 4/1 pair counts as a miss.
  assign check_fail = (bus.in_out4 !== bus.in_out1) | $isunknown(bus.in_out5);

  // NOTE: every _d gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    mismatch_d  = push & check_fail;
    err_count_d = err_count_q;

    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    if (push && check_fail && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

    // Registered from next state, so out_ready never reaches in_ready combinationally.
    in_ready_d = (state_d != FULL);
  end

  // NOTE: storage is cleared on reset too, so a stale entry can never reappear on q_out*.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      in_ready_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge _d values together.
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      in_ready_q  <= in_ready_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
    end
  end

  assign head          = (state_q != EMPTY) ? mem_q[rd_ptr_q] : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.q_out1    = head[0];
  assign bus.q_out2    = head[1];
  assign bus.q_out3    = head[2];
  assign bus.q_out4    = head[3];
  assign bus.q_out5    = head[4];
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_comb_capture.sv
// Bench for comb_capture (size=4): directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_comb_capture;

  localparam int SZ = 4;
  typedef logic [4:0][SZ-1:0] ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  comb_capture_if #(.size(SZ)) bus ();

  comb_capture #(.size(SZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t       mq[$];
  logic       m_ready = 1'b0;
  logic       m_mism  = 1'b0;
  int         m_errs  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int a, input int b, input int c, input int d, input int e);
    ent_t t;
    t[0] = a[SZ-1:0]; t[1] = b[SZ-1:0]; t[2] = c[SZ-1:0]; t[3] = d[SZ-1:0]; t[4] = e[SZ-1:0];
    return t;
  endfunction

  task automatic model_edge();
    ent_t f;
    logic push, pop, fail;
    if (!reset_n) begin
      mq.delete();
      m_ready = 1'b0;
      m_mism  = 1'b0;
      m_errs  = 0;
    end else begin
      f    = {bus.in_out5, bus.in_out4, bus.in_out3, bus.in_out2, bus.in_out1};
      push = bus.in_valid && m_ready;
      pop  = (mq.size() > 0) && bus.out_ready;
      fail = (f[3] !== f[0]) || $isunknown(f[4]);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(f);
      m_ready = (mq.size() < 2);
      m_mism  = push && fail;
      if (push && fail && m_errs < 255) m_errs++;
    end
  endtask

  task automatic compare_all();
    ent_t exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : '0;
    check("in_ready",  bus.in_ready,  m_ready);
    check("out_valid", bus.out_valid, mq.size() > 0);
    check("q_out",     {bus.q_out5, bus.q_out4, bus.q_out3, bus.q_out2, bus.q_out1}, exp_head);
    check("mismatch",  bus.mismatch,  m_mism);
    check("err_count", bus.err_count, m_errs[7:0]);
  endtask

  task automatic step(input logic rst_v, input logic v, input ent_t f, input logic ordy);
    reset_n       = rst_v;
    bus.in_valid  = v;
    bus.in_out1   = f[0];
    bus.in_out2   = f[1];
    bus.in_out3   = f[2];
    bus.in_out4   = f[3];
    bus.in_out5   = f[4];
    bus.out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    ent_t a, b, c, f;
    logic [SZ-1:0] x5;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    {bus.in_out5, bus.in_out4, bus.in_out3, bus.in_out2, bus.in_out1} = '0;

    // Reset, then release: in_ready rises one edge after release
    step(1'b0, 1'b1, mk(1, 1, 1, 1, 1), 1'b1);
    step(1'b0, 1'b1, mk(1, 1, 1, 1, 1), 1'b1);
    check("rst_in_ready", bus.in_ready, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("release_in_ready", bus.in_ready, 1'b1);

    // Single beat, pass-through with out_ready high
    step(1'b1, 1'b1, mk(1, 2, 3, 1, 5), 1'b1);
    check("first_q", {bus.q_out5, bus.q_out4, bus.q_out3, bus.q_out2, bus.q_out1}, mk(1, 2, 3, 1, 5));
    step(1'b1, 1'b0, '0, 1'b1);

    // Fill with out_ready low; third beat must be dropped, then drain in order
    a = mk(4, 6, 7, 4, 9);
    b = mk(8, 10, 11, 8, 12);
    c = mk(13, 14, 15, 13, 3);
    step(1'b1, 1'b1, a, 1'b0);
    step(1'b1, 1'b1, b, 1'b0);
    check("full_in_ready", bus.in_ready, 1'b0);
    step(1'b1, 1'b1, c, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("drain_b", {bus.q_out5, bus.q_out4, bus.q_out3, bus.q_out2, bus.q_out1}, b);
    step(1'b1, 1'b0, '0, 1'b1);
    check("drained", bus.out_valid, 1'b0);

    // ONE state: push B and pop A together, B becomes head
    step(1'b1, 1'b1, a, 1'b0);
    step(1'b1, 1'b1, b, 1'b1);
    check("swap_head", {bus.q_out5, bus.q_out4, bus.q_out3, bus.q_out2, bus.q_out1}, b);
    step(1'b1, 1'b0, '0, 1'b1);

    // Field 4 vs field 1 differ, then an unknown bit in field 5
    step(1'b1, 1'b1, mk(1, 0, 0, 3, 0), 1'b1);
    check("mism_pulse", bus.mismatch, 1'b1);
    f = mk(2, 0, 0, 2, 0);
    x5 = 4'b00x0;
    f[4] = x5;
    step(1'b1, 1'b1, f, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("mism_clear", bus.mismatch, 1'b0);

    // Saturation: 300 consecutive failing beats
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, mk(i, i + 1, 0, i + 1, 0), 1'b1);
    check("err_sat", bus.err_count, 8'd255);
    check("sat_pulse", bus.mismatch, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);

    // Reset while FULL with errors recorded
    step(1'b1, 1'b1, mk(1, 0, 0, 2, 0), 1'b0);
    step(1'b1, 1'b1, mk(3, 0, 0, 4, 0), 1'b0);
    step(1'b0, 1'b1, mk(5, 0, 0, 5, 0), 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_err", bus.err_count, 8'd0);
    step(1'b1, 1'b0, '0, 1'b0);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      f = ent_t'($urandom);
      if ($urandom_range(3) != 0) f[3] = f[0];
      step(($urandom_range(63) != 0), $urandom_range(1) == 1, f, $urandom_range(2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comb_capture.md
COMB_CAPTURE -- requirements
Module: comb_capture

Interface
REQ-001 Parameter: size, default 1, data width of every captured field; legal range 1..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port: in_valid  input  1  upstream beat present.
REQ-005 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-006 Port: in_out1..in_out5  input  size each  five result fields from the combinational stage.
REQ-007 Port: out_valid  output  1  head entry present.
REQ-008 Port: out_ready  input  1  downstream consumes head this cycle.
REQ-009 Port: q_out1..q_out5  output  size each  head-entry fields.
REQ-010 Port: mismatch  output  1  one-cycle pulse flagging a failed consistency check.
REQ-011 Port: err_count  output  8  saturating count of mismatches.

Function
REQ-012 Storage SHALL be a 2-entry FIFO, each entry holding all five fields; write/read pointers 1 bit each, wrapping 1->0.
REQ-013 State SHALL be one of EMPTY, ONE, FULL, registered.
REQ-014 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-015 in_ready SHALL be 1 iff state != FULL and reset_n was high at the last edge; no combinational path from out_ready to in_ready.
REQ-016 out_valid SHALL be 1 iff state != EMPTY; q_out1..q_out5 SHALL show the entry at the read pointer, all zero when EMPTY.
REQ-017 Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE; all other cases hold.
REQ-018 In ONE with simultaneous push and pop, the popped entry SHALL be the old head and the pushed entry SHALL be head on the next cycle.
REQ-019 Latency: a beat pushed at edge N into EMPTY SHALL appear on q_out* with out_valid=1 after edge N.
REQ-020 In FULL, in_valid SHALL be ignored: no write, no pointer move, no check.
REQ-021 Ordering SHALL be strict FIFO; no entry dropped or duplicated across any push/pop combination.
REQ-022 Check on each push: fail if in_out4 differs from in_out1 under 4-state comparison (any X/Z bit difference counts), or if in_out5 contains any X/Z bit.
REQ-023 mismatch SHALL be 1 for exactly the cycle after a failing push, 0 otherwise.
REQ-024 err_count SHALL increment by 1 on each failing push and saturate at 255.
REQ-025 Checks SHALL NOT depend on out_ready; a failing push into a full-then-draining FIFO still counts once.

Reset
REQ-026 While reset_n is low at a rising edge: state <= EMPTY, pointers <= 0, storage <= 0, mismatch <= 0, err_count <= 0, in_ready <= 0.
REQ-027 First edge with reset_n high SHALL set in_ready to 1; pushes are accepted from the following cycle.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; out_valid SHALL be 0 after that edge regardless of in_valid/out_ready.

Verification
REQ-029 size=4, out_ready=1, push {1,2,3,1,5} -> next cycle out_valid=1, q_out*={1,2,3,1,5}, mismatch=0, err_count=0.
REQ-030 size=4, out_ready=0, push A, B, C on three consecutive cycles -> in_ready=0 after second push, C ignored; then out_ready=1 -> A then B, then out_valid=0.
REQ-031 ONE state holding A, push B and pop A in the same cycle -> next cycle state ONE, q_out*=B.
REQ-032 size=2, push in_out1=2'b01, in_out4=2'b11 -> mismatch=1 one cycle later, err_count=1; in_out5=2'b0x on next push -> err_count=2.
REQ-033 300 failing pushes with out_ready=1 -> err_count stops at 255, mismatch still pulses per failure.
REQ-034 FULL with errors recorded, reset_n=0 one cycle -> out_valid=0, err_count=0, in_ready=0, then in_ready=1 one cycle after release.
